// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, the delayed sync/blank bundle and a small
// window-decode helper used by the timing generator and the renderers.
package vga_timing_pkg;

  localparam int VGA_CW    = 10;
  localparam int MAX_TOTAL = 32'd1024;

  localparam int H_VISIBLE = 32'd640;
  localparam int H_FP      = 32'd16;
  localparam int H_SYNC    = 32'd96;
  localparam int H_BP      = 32'd48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 32'd480;
  localparam int V_FP      = 32'd10;
  localparam int V_SYNC    = 32'd2;
  localparam int V_BP      = 32'd33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Bit order matches the delay-line reset vector 3'b011 (blank low, syncs high).
  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
  } vga_sync_t;

  localparam logic [2:0] SYNC_IDLE = 3'b011;

  function automatic logic in_window(input logic [VGA_CW:0] pos,
                                     input logic [VGA_CW:0] lo,
                                     input logic [VGA_CW:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register for a small bus; every stage resets to RST_VAL so the
// output reads idle until real data has propagated through.
module vga_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);
  import vga_timing_pkg::*;

  logic [DEPTH-1:0][WIDTH-1:0] stage_r;

  // Shift chain: stage 0 captures the input, later stages follow one cycle apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= {DEPTH{RST_VAL}};
    end else begin
      stage_r[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign delayed = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel/line counters, sync and blank decode delayed to match
// renderer colour latency, plus line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP       = vga_timing_pkg::H_FP,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BP       = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP       = vga_timing_pkg::V_FP,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BP       = vga_timing_pkg::V_BP,
  parameter int PIPE_DELAY = 32'd1
) (
  input  logic                              vga_clk,
  input  logic                              reset_n,
  output logic [vga_timing_pkg::VGA_CW-1:0] DrawX,
  output logic [vga_timing_pkg::VGA_CW-1:0] DrawY,
  output logic                              blank,
  output logic                              hs,
  output logic                              vs,
  output logic                              line_start,
  output logic                              frame_start,
  output logic [15:0]                       frame_count
);
  import vga_timing_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [VGA_CW-1:0] H_LAST = VGA_CW'(H_TOT - 1);
  localparam logic [VGA_CW-1:0] V_LAST = VGA_CW'(V_TOT - 1);

  // One extra bit so a window ending exactly at 1024 still decodes correctly.
  localparam logic [VGA_CW:0] H_VIS_END = (VGA_CW+1)'(H_VISIBLE);
  localparam logic [VGA_CW:0] HS_LO     = (VGA_CW+1)'(H_VISIBLE + H_FP);
  localparam logic [VGA_CW:0] HS_HI     = (VGA_CW+1)'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VGA_CW:0] V_VIS_END = (VGA_CW+1)'(V_VISIBLE);
  localparam logic [VGA_CW:0] VS_LO     = (VGA_CW+1)'(V_VISIBLE + V_FP);
  localparam logic [VGA_CW:0] VS_HI     = (VGA_CW+1)'(V_VISIBLE + V_FP + V_SYNC);

  if ((H_TOT > MAX_TOTAL) || (V_TOT > MAX_TOTAL)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if ((PIPE_DELAY < 32'd1) || (PIPE_DELAY > 32'd4)) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 1..4");
  end

  logic [VGA_CW-1:0] hc_r;
  logic [VGA_CW-1:0] vc_r;
  logic              line_start_r;
  logic              frame_start_r;
  logic [15:0]       frame_count_r;
  logic              line_end_s;
  logic              frame_end_s;
  vga_sync_t         raw_s;
  vga_sync_t         sync_s;

  assign line_end_s  = (hc_r == H_LAST);
  assign frame_end_s = line_end_s && (vc_r == V_LAST);

  // Raster counters, wrap strobes and frame counter.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_r          <= {VGA_CW{1'b0}};
      vc_r          <= {VGA_CW{1'b0}};
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      line_start_r  <= line_end_s;
      frame_start_r <= frame_end_s;
      if (line_end_s) begin
        hc_r <= {VGA_CW{1'b0}};
        if (frame_end_s) begin
          vc_r          <= {VGA_CW{1'b0}};
          frame_count_r <= frame_count_r + 16'd1;
        end else begin
          vc_r <= vc_r + {{(VGA_CW-1){1'b0}}, 1'b1};
        end
      end else begin
        hc_r <= hc_r + {{(VGA_CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Undelayed decode of the current counter position.
  always_comb begin
    raw_s.blank = ({1'b0, hc_r} < H_VIS_END) && ({1'b0, vc_r} < V_VIS_END);
    raw_s.hs    = !in_window({1'b0, hc_r}, HS_LO, HS_HI);
    raw_s.vs    = !in_window({1'b0, vc_r}, VS_LO, VS_HI);
  end

  vga_delay_line #(
    .WIDTH   ($bits(vga_sync_t)),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk     (vga_clk),
    .rst_n   (reset_n),
    .data    (raw_s),
    .delayed (sync_s)
  );

  assign DrawX       = hc_r;
  assign DrawY       = vc_r;
  assign blank       = sync_s.blank;
  assign hs          = sync_s.hs;
  assign vs          = sync_s.vs;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign frame_count = frame_count_r;

endmodule
